// File: rtl/alu_slice_pkg.sv
// Shared encodings for the bit-slice ALU: microinstruction fields, sequencer state, op select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_slice_pkg;

  // Source operand pair (R,S) selected by I[2:0]
  typedef enum logic [2:0] {
    SRC_AQ = 3'd0,
    SRC_AB = 3'd1,
    SRC_ZQ = 3'd2,
    SRC_ZB = 3'd3,
    SRC_ZA = 3'd4,
    SRC_DA = 3'd5,
    SRC_DQ = 3'd6,
    SRC_DZ = 3'd7
  } src_e;

  // ALU function selected by I[5:3]
  typedef enum logic [2:0] {
    FN_ADD   = 3'd0,
    FN_SUBR  = 3'd1,
    FN_SUBS  = 3'd2,
    FN_OR    = 3'd3,
    FN_AND   = 3'd4,
    FN_NOTRS = 3'd5,
    FN_EXOR  = 3'd6,
    FN_EXNOR = 3'd7
  } fn_e;

  // Destination / shift control selected by I[8:6]
  typedef enum logic [2:0] {
    DST_QREG  = 3'd0,
    DST_NOP   = 3'd1,
    DST_RAMA  = 3'd2,
    DST_RAMF  = 3'd3,
    DST_RAMQD = 3'd4,
    DST_RAMD  = 3'd5,
    DST_RAMQU = 3'd6,
    DST_RAMU  = 3'd7
  } dst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } seq_st_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/alu_slice_core.sv
// Combinational source mux, ALU and status flags for one WIDTH-bit slice.
// Latency: zero cycles, purely combinational.
// Backpressure: none. Ports: src/fn select, a/b/q/d operands, cin -> f, cout, ovr, zero, sign.
module alu_slice_core
  import alu_slice_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  src_e             src,
  input  fn_e              fn,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] q_val,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             sign
);

  logic [WIDTH-1:0] r, s, r_op, s_op;
  logic [WIDTH:0]   sum;
  logic             arith;

  always_comb begin
    r = '0;
    s = '0;
    case (src)
      SRC_AQ:  begin r = a_val; s = q_val; end
      SRC_AB:  begin r = a_val; s = b_val; end
      SRC_ZQ:  begin r = '0;    s = q_val; end
      SRC_ZB:  begin r = '0;    s = b_val; end
      SRC_ZA:  begin r = '0;    s = a_val; end
      SRC_DA:  begin r = d;     s = a_val; end
      SRC_DQ:  begin r = d;     s = q_val; end
      SRC_DZ:  begin r = d;     s = '0;    end
      default: begin r = '0;    s = '0;    end
    endcase
  end

  // Subtracts are done as add-with-inverted-operand so one adder serves all three.
  assign r_op  = (fn == FN_SUBR) ? ~r : r;
  assign s_op  = (fn == FN_SUBS) ? ~s : s;
  assign sum   = {1'b0, r_op} + {1'b0, s_op} + {{WIDTH{1'b0}}, cin};
  assign arith = (fn == FN_ADD) || (fn == FN_SUBR) || (fn == FN_SUBS);

  always_comb begin
    f = '0;
    case (fn)
      FN_ADD, FN_SUBR, FN_SUBS: f = sum[WIDTH-1:0];
      FN_OR:    f = r | s;
      FN_AND:   f = r & s;
      FN_NOTRS: f = ~r & s;
      FN_EXOR:  f = r ^ s;
      FN_EXNOR: f = ~(r ^ s);
      default:  f = '0;
    endcase
  end

  // Carry and overflow only carry meaning for the arithmetic functions.
  assign cout = arith & sum[WIDTH];
  assign ovr  = arith & (r_op[WIDTH-1] == s_op[WIDTH-1]) & (sum[WIDTH-1] != r_op[WIDTH-1]);
  assign zero = (f == '0);
  assign sign = f[WIDTH-1];

endmodule

// File: rtl/alu_slice_seq.sv
// Bit-slice ALU with register file, Q register and built-in multiply/divide sequencer.
// Latency: ALU path combinational; mul/div take WIDTH+1 edges from start to done.
// Backpressure: start and microinstruction writes are ignored while busy.
// Ports: I/aadd/badd/d/cin/shift fills -> y + flags; start/op -> busy/done/div_zero.
module alu_slice_seq
  import alu_slice_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       I,
  input  logic [AW-1:0]    aadd,
  input  logic [AW-1:0]    badd,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             ram_lsb_in,
  input  logic             ram_msb_in,
  input  logic             q_lsb_in,
  input  logic             q_msb_in,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             sign,
  input  logic             start,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] a_val, b_val, f;
  dst_e             dst;

  seq_st_e          st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_d, dz_q, dz_d, lat_en;
  logic [AW-1:0]    aadd_l, badd_l;

  logic [WIDTH-1:0] seq_a, seq_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_ext;
  logic             div_borrow;
  logic [WIDTH-1:0] div_r;

  assign a_val = rf[aadd];
  assign b_val = rf[badd];
  assign dst   = dst_e'(I[8:6]);

  alu_slice_core #(.WIDTH(WIDTH)) u_core (
    .src   (src_e'(I[2:0])),
    .fn    (fn_e'(I[5:3])),
    .a_val (a_val),
    .b_val (b_val),
    .q_val (q_q),
    .d     (d),
    .cin   (cin),
    .f     (f),
    .cout  (cout),
    .ovr   (ovr),
    .zero  (zero),
    .sign  (sign)
  );

  assign y = (dst == DST_RAMA) ? a_val : f;

  // Sequencer datapath works on the addresses captured at start, not the live ones.
  assign seq_a   = rf[aadd_l];
  assign seq_b   = rf[badd_l];
  assign mul_sum = {1'b0, seq_b} + (q_q[0] ? {1'b0, seq_a} : '0);
  // Partial remainder shifted left one place; the extra top bit keeps the compare exact.
  assign div_ext    = {seq_b, q_q[WIDTH-1]};
  assign div_borrow = (div_ext < {1'b0, seq_a});
  // When no borrow the true difference is below the divisor, so WIDTH bits hold it.
  assign div_r      = div_borrow ? div_ext[WIDTH-1:0] : (div_ext[WIDTH-1:0] - seq_a);

  assign busy     = (st_q != ST_IDLE);
  assign div_zero = dz_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    lat_en = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          lat_en = 1'b1;
          cnt_d  = '0;
          if (op == OP_DIV && a_val == '0) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            dz_d = 1'b0;
            st_d = (op == OP_DIV) ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      done   <= 1'b0;
      dz_q   <= 1'b0;
      aadd_l <= '0;
      badd_l <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      done  <= done_d;
      dz_q  <= dz_d;
      if (lat_en) begin
        aadd_l <= aadd;
        badd_l <= badd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) rf[k] <= '0;
      q_q <= '0;
    end else begin
      case (st_q)
        ST_MUL: begin
          rf[badd_l] <= mul_sum[WIDTH:1];
          q_q        <= {mul_sum[0], q_q[WIDTH-1:1]};
        end
        ST_DIV: begin
          rf[badd_l] <= div_r;
          q_q        <= {q_q[WIDTH-2:0], ~div_borrow};
        end
        default: begin
          case (dst)
            DST_QREG:  q_q <= f;
            DST_RAMA,
            DST_RAMF:  rf[badd] <= f;
            DST_RAMQD: begin
              rf[badd] <= {ram_msb_in, f[WIDTH-1:1]};
              q_q      <= {q_msb_in, q_q[WIDTH-1:1]};
            end
            DST_RAMD:  rf[badd] <= {ram_msb_in, f[WIDTH-1:1]};
            DST_RAMQU: begin
              rf[badd] <= {f[WIDTH-2:0], ram_lsb_in};
              q_q      <= {q_q[WIDTH-2:0], q_lsb_in};
            end
            DST_RAMU:  rf[badd] <= {f[WIDTH-2:0], ram_lsb_in};
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
module tb_alu_slice_seq;

  localparam int W = 16;
  localparam int N = 16;

  localparam int S_AB = 1, S_ZQ = 2, S_ZB = 3, S_ZA = 4, S_DA = 5, S_DZ = 7;
  localparam int F_ADD = 0, F_SUBR = 1, F_SUBS = 2;
  localparam int D_QREG = 0, D_NOP = 1, D_RAMA = 2, D_RAMF = 3, D_RAMQD = 4,
                 D_RAMD = 5, D_RAMQU = 6, D_RAMU = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [8:0]   I = '0;
  logic [3:0]   aadd = '0, badd = '0;
  logic [W-1:0] d = '0;
  logic         cin = 1'b0, ram_lsb_in = 1'b0, ram_msb_in = 1'b0;
  logic         q_lsb_in = 1'b0, q_msb_in = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] y;
  logic         cout, ovr, zero, sign, busy, done, div_zero;

  alu_slice_seq #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .aadd(aadd), .badd(badd), .d(d), .y(y),
    .cin(cin), .ram_lsb_in(ram_lsb_in), .ram_msb_in(ram_msb_in),
    .q_lsb_in(q_lsb_in), .q_msb_in(q_msb_in), .cout(cout), .ovr(ovr),
    .zero(zero), .sign(sign), .start(start), .op(op), .busy(busy),
    .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int dst, input int fn, input int src);
    logic [8:0] v;
    v = {3'(dst), 3'(fn), 3'(src)};
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0] f;
    logic [W-1:0] y;
    logic         cout;
    logic         ovr;
    logic         zero;
    logic         sign;
  } res_t;

  function automatic longint sx(input logic [W-1:0] v);
    longint r;
    r = $signed(v);
    return r;
  endfunction

  // Arithmetic in plain integers: carry is the 2^W bit of the true unsigned
  // sum, overflow is the signed sum falling outside the W-bit signed range.
  function automatic res_t model_alu(input logic [8:0] ii, input logic [W-1:0] a, b, q, dd,
                                     input logic c);
    res_t r;
    logic [W-1:0] ru, su;
    longint full, sres, maxu;
    logic arith;
    r = '0; ru = '0; su = '0; full = 0; sres = 0; arith = 1'b1;
    maxu = (longint'(1) << W) - 1;
    case (ii[2:0])
      3'd0: begin ru = a;  su = q;  end
      3'd1: begin ru = a;  su = b;  end
      3'd2: begin ru = '0; su = q;  end
      3'd3: begin ru = '0; su = b;  end
      3'd4: begin ru = '0; su = a;  end
      3'd5: begin ru = dd; su = a;  end
      3'd6: begin ru = dd; su = q;  end
      default: begin ru = dd; su = '0; end
    endcase
    case (ii[5:3])
      3'd0: begin full = longint'(ru) + longint'(su) + longint'(c);
                  sres = sx(ru) + sx(su) + longint'(c); end
      3'd1: begin full = longint'(su) + (maxu - longint'(ru)) + longint'(c);
                  sres = sx(su) - sx(ru) - 1 + longint'(c); end
      3'd2: begin full = longint'(ru) + (maxu - longint'(su)) + longint'(c);
                  sres = sx(ru) - sx(su) - 1 + longint'(c); end
      3'd3: begin arith = 1'b0; r.f = ru | su; end
      3'd4: begin arith = 1'b0; r.f = ru & su; end
      3'd5: begin arith = 1'b0; r.f = ~ru & su; end
      3'd6: begin arith = 1'b0; r.f = ru ^ su; end
      default: begin arith = 1'b0; r.f = ~(ru ^ su); end
    endcase
    if (arith) begin
      r.f    = full[W-1:0];
      r.cout = full[W];
      r.ovr  = (sres > (longint'(1) << (W-1)) - 1) || (sres < -(longint'(1) << (W-1)));
    end
    r.zero = (r.f == '0);
    r.sign = r.f[W-1];
    r.y    = (ii[8:6] == 3'd2) ? a : r.f;
    return r;
  endfunction

  logic [W-1:0] mreg [N];
  logic [W-1:0] mq = '0;
  int           m_left = 0;
  logic         m_done = 1'b0, m_dz = 1'b0;
  logic [3:0]   m_pb = '0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  longint       ta, th, tl, tp;
  res_t         mr, cr;

  // Whole-operation model: results are computed at acceptance with * / %
  // and appear in the register file when the busy window closes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) mreg[k] = '0;
      mq = '0; m_left = 0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          mreg[m_pb] = m_hi;
          mq = m_lo;
          m_done = 1'b1;
        end
      end else if (start) begin
        ta = longint'(mreg[aadd]);
        th = longint'(mreg[badd]);
        tl = longint'(mq);
        if (op && ta == 0) begin
          m_dz = 1'b1;
          m_done = 1'b1;
        end else begin
          m_dz = 1'b0;
          m_pb = badd;
          m_left = W;
          if (!op) begin
            tp = ta * tl + th;
            m_hi = W'(tp >> W);
            m_lo = W'(tp);
          end else begin
            tp = (th << W) | tl;
            m_lo = W'(tp / ta);
            m_hi = W'(tp % ta);
          end
        end
      end else begin
        mr = model_alu(I, mreg[aadd], mreg[badd], mq, d, cin);
        case (I[8:6])
          3'd0: mq = mr.f;
          3'd2, 3'd3: mreg[badd] = mr.f;
          3'd4: begin mreg[badd] = {ram_msb_in, mr.f[W-1:1]}; mq = {q_msb_in, mq[W-1:1]}; end
          3'd5: mreg[badd] = {ram_msb_in, mr.f[W-1:1]};
          3'd6: begin mreg[badd] = {mr.f[W-2:0], ram_lsb_in}; mq = {mq[W-2:0], q_lsb_in}; end
          3'd7: mreg[badd] = {mr.f[W-2:0], ram_lsb_in};
          default: ;
        endcase
      end
    end
  end

  // Compare process: control outputs every cycle, ALU outputs whenever the
  // model state is architecturally defined (not mid-sequence).
  always @(negedge clk) begin
    cr = model_alu(I, mreg[aadd], mreg[badd], mq, d, cin);
    chk("busy", busy, (m_left != 0));
    chk("done", done, m_done);
    chk("div_zero", div_zero, m_dz);
    if (m_left == 0) begin
      chk("y", y, cr.y);
      chk("cout", cout, cr.cout);
      chk("ovr", ovr, cr.ovr);
      chk("zero", zero, cr.zero);
      chk("sign", sign, cr.sign);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic load_reg(input int r, input logic [W-1:0] v);
    I = mk(D_RAMF, F_ADD, S_DZ); badd = 4'(r); d = v; cin = 1'b0; tick();
  endtask

  task automatic load_q(input logic [W-1:0] v);
    I = mk(D_QREG, F_ADD, S_DZ); d = v; cin = 1'b0; tick();
  endtask

  task automatic read_reg(input int r, input logic [W-1:0] exp, input string name);
    I = mk(D_NOP, F_ADD, S_ZA); aadd = 4'(r); cin = 1'b0;
    at_neg(); chk(name, y, exp); tick();
  endtask

  task automatic read_q(input logic [W-1:0] exp, input string name);
    I = mk(D_NOP, F_ADD, S_ZQ); cin = 1'b0;
    at_neg(); chk(name, y, exp); tick();
  endtask

  // Issues start at the next edge and returns at the done cycle (negedge+1).
  task automatic run_seq(input logic o, input int a, input int b, input bit poke,
                         input int exp_busy, input int exp_edges);
    int bcnt, edges;
    bit got;
    bcnt = 0; edges = 0; got = 1'b0;
    I = mk(D_NOP, F_ADD, S_ZQ); cin = 1'b0;
    start = 1'b1; op = o; aadd = 4'(a); badd = 4'(b);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      at_neg();
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin got = 1'b1; edges = k; break; end
      if (poke && k == 3) begin
        start = 1'b1; I = mk(D_RAMF, F_ADD, S_DZ); badd = 4'd5; d = 16'hDEAD;
      end else if (k == 4) begin
        start = 1'b0; I = mk(D_NOP, F_ADD, S_ZQ); badd = 4'(b);
      end
    end
    chk("seq_done_seen", got, 1'b1);
    chk("seq_busy_cycles", W'(bcnt), W'(exp_busy));
    chk("seq_start_to_done", W'(edges), W'(exp_edges));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    I = mk(D_NOP, F_ADD, S_ZA);
    tick(); tick();
    at_neg();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_y", y, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // ADD overflow into RAMF
    load_reg(1, 16'h7FFF);
    I = mk(D_RAMF, F_ADD, S_DA); aadd = 4'd1; badd = 4'd1; d = 16'h0001; cin = 1'b0;
    at_neg();
    chk("add_y", y, 16'h8000);
    chk("add_ovr", ovr, 1'b1);
    chk("add_cout", cout, 1'b0);
    chk("add_sign", sign, 1'b1);
    tick();
    read_reg(1, 16'h8000, "ramf_writeback");

    // Subtracts and the rest of the function set
    load_reg(6, 16'h0F0F);
    load_reg(7, 16'h00FF);
    I = mk(D_NOP, F_SUBR, S_AB); aadd = 4'd6; badd = 4'd7; cin = 1'b1;
    at_neg(); chk("subr_y", y, 16'hF1F0); chk("subr_cout", cout, 1'b0); tick();
    I = mk(D_NOP, F_SUBS, S_AB); cin = 1'b1;
    at_neg(); chk("subs_y", y, 16'h0E10); chk("subs_cout", cout, 1'b1); tick();
    for (int fn = 0; fn < 8; fn++) begin
      I = mk(D_NOP, fn, S_AB); cin = 1'(fn); tick();
    end

    // RAMD with MSB fill
    load_reg(5, 16'h0002);
    I = mk(D_RAMD, F_ADD, S_ZB); badd = 4'd5; cin = 1'b0; ram_msb_in = 1'b1; tick();
    ram_msb_in = 1'b0;
    read_reg(5, 16'h8001, "ramd_shift");

    // Shift destinations exercised against the model
    load_reg(8, 16'hA5C3);
    load_q(16'h3C5A);
    for (int k = 0; k < 8; k++) begin
      I = mk(k, F_ADD, S_ZB); badd = 4'd8; aadd = 4'd6;
      ram_msb_in = 1'(k); ram_lsb_in = ~1'(k); q_msb_in = ~1'(k); q_lsb_in = 1'(k);
      tick();
    end
    ram_msb_in = 1'b0; ram_lsb_in = 1'b0; q_msb_in = 1'b0; q_lsb_in = 1'b0;

    // Multiply, with a start and a write attempted mid-sequence
    load_reg(2, 16'h1234);
    load_reg(3, 16'h0000);
    load_q(16'h0010);
    run_seq(1'b0, 2, 3, 1'b1, W, W + 1);
    tick();
    read_reg(3, 16'h0001, "mul_hi");
    read_q(16'h2340, "mul_lo");
    read_reg(5, 16'h8001, "busy_write_ignored");

    // Divide
    load_reg(3, 16'h0000);
    load_q(16'd100);
    load_reg(2, 16'd7);
    run_seq(1'b1, 2, 3, 1'b0, W, W + 1);
    chk("div_zero_clear", div_zero, 1'b0);
    tick();
    read_reg(3, 16'd2, "div_rem");
    read_q(16'd14, "div_quot");

    // Back-to-back divides: second start issued in the first done cycle
    run_seq(1'b1, 2, 3, 1'b0, W, W + 1);
    run_seq(1'b1, 2, 3, 1'b0, W, W + 1);
    tick();
    read_reg(3, 16'd2, "b2b_rem");
    read_q(16'h9CBC, "b2b_quot");

    // Divide by zero
    load_reg(4, 16'h0000);
    run_seq(1'b1, 4, 3, 1'b0, 0, 1);
    chk("dz_flag", div_zero, 1'b1);
    tick();
    chk("dz_held", div_zero, 1'b1);
    read_reg(3, 16'd2, "dz_rem_kept");
    read_q(16'h9CBC, "dz_q_kept");

    // Reset in the middle of a multiply
    I = mk(D_NOP, F_ADD, S_ZQ); start = 1'b1; op = 1'b0; aadd = 4'd2; badd = 4'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    at_neg();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) read_reg(r, '0, "rst_reg_clear");
    read_q('0, "rst_q_clear");

    // Normal multiply after reset
    load_reg(2, 16'd3);
    load_q(16'd5);
    run_seq(1'b0, 2, 3, 1'b0, W, W + 1);
    tick();
    read_reg(3, 16'd0, "post_rst_mul_hi");
    read_q(16'd15, "post_rst_mul_lo");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_slice_seq.md
# alu_slice_seq

Parametrised successor to the four-bit bit-slice ALU: one WIDTH-bit slice with an NREGS-entry two-port register file, Q register and the same 9-bit source/function/destination microinstruction encoding. Adds asynchronous reset and a built-in iterative sequencer for unsigned multiply (shift-add) and unsigned divide (restoring), so microcode issues one start instead of WIDTH step microinstructions. Sits in the micro-BESM datapath, driven by the microsequencer.

## Interface
- WIDTH, 16, data path width (≥4)
- NREGS, 16, register file depth (power of two ≥2); AW = $clog2(NREGS)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- I  in  9  microinstruction: [2:0] source, [5:3] function, [8:6] destination
- aadd, badd  in  AW  A-port read address; B-port read/write address
- d  in  WIDTH  external data operand
- y  out  WIDTH  data output: A-port value if destination = 010, else F
- cin  in  1  ALU carry in
- ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in  in  1  shift fill bits
- cout, ovr, zero, sign  out  1  carry out, signed overflow, F==0, F[WIDTH-1]
- start  in  1  begin sequence op (sampled only in IDLE)
- op  in  1  0 = multiply, 1 = divide
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse
- div_zero  out  1  divisor was zero; held until next start

## Operation
- Sources/functions/destinations keep the 4-bit slice encoding, widened to WIDTH. ADD/SUBR/SUBS compute R+S+cin (operand inverted for SUB); logic ops as before; cout = bit WIDTH of the extended sum; ovr from MSB sign rule.
- Register file and Q read combinationally (no latch); writes on rising edge per destination: RAMF, RAMD (shift right, ram_msb_in fills MSB), RAMU (shift left, ram_lsb_in fills LSB); QREG, Q shift right (q_msb_in), Q shift left (q_lsb_in).
- Sequencer states: IDLE, MUL, DIV. Enter MUL/DIV on start && !busy; latch aadd, badd, op; clear step counter.
- MUL step (WIDTH times): sum = reg[badd] + (Q[0] ? reg[aadd] : 0) at WIDTH+1 bits; {reg[badd], Q} ← {sum, Q} >> 1. Result: high word in reg[badd], low in Q.
- DIV step (WIDTH times): {R, Q} ← {R, Q} << 1; trial = R − reg[aadd] at WIDTH+1 bits; no borrow → R = trial, Q[0] = 1. R is reg[badd]; caller preloads R = 0 (or high dividend < divisor), Q = dividend. Result: quotient in Q, remainder in reg[badd].
- Divisor zero at start: no step, no write, div_zero = 1, done next cycle.
- While busy: I writes suppressed, start ignored; y/flags still reflect combinational ALU on current I.
- Reset (any time, including mid-sequence): all registers, Q, step counter cleared; state IDLE; busy, done, div_zero = 0. y/flags then follow combinational function of zeroed state.

## Timing
- ALU path combinational: y/flags valid same cycle as I, aadd, badd, d.
- start sampled at edge 0: busy = 1 from edge 0 through edge WIDTH (WIDTH steps at edges 1..WIDTH); busy = 0 and done = 1 for the cycle after edge WIDTH; results readable that cycle. Start-to-done = WIDTH+1 edges.
- Divide-by-zero: busy stays 0; done and div_zero = 1 after edge 0.
- start in the done cycle is accepted (back-to-back).

## Structure
- Package alu_slice_pkg: enums for source, function, destination codes; sequencer state enum; op constants.
- One sub-module alu_slice_core: combinational WIDTH-parametrised source mux + ALU + flags, shared by normal mode; sequencer adders stay in top.

## Test plan
- WIDTH=16: reg[1]=0x7FFF, d=1, source D,A, ADD, RAMF to badd=1, cin=0 → y=0x8000, ovr=1, cout=0, sign=1; reg[1]=0x8000 next cycle.
- MUL: reg[2]=0x1234 (aadd), reg[3]=0 (badd), Q=0x0010 → done after 17 edges; reg[3]=0x0001, Q=0x2340; busy high exactly 16 cycles.
- DIV: reg[3]=0, Q=100, reg[2]=7 → Q=14, reg[3]=2, div_zero=0.
- DIV with reg[2]=0 → done and div_zero next cycle; reg[3], Q unchanged.
- Reset asserted at MUL step 5 → busy, done immediately 0; all regs and Q read 0; new start after release completes normally.
- RAMD on 0x0002 with ram_msb_in=1 → 0x8001; start pulsed while busy and an I write → ignored, register unchanged.
